// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - handshaked opcode decoder with multi-cycle mul/div sequencing
// Decodes an accepted opcode to a one-hot ALU select and times mul/div with a latency counter.
module alu_op_sequencer #(
  parameter int OPW     = 5,
  parameter int MUL_LAT = 32,
  parameter int DIV_LAT = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [OPW-1:0] opcode,
  input  logic           kill,
  output logic           in_ready,
  output logic [7:0]     sel,
  output logic           md_start,
  output logic           busy,
  output logic           out_valid,
  output logic           illegal
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNTW   = $clog2(MAXLAT + 1);
  localparam logic [CNTW-1:0] MUL_CNT = CNTW'(MUL_LAT - 1);
  localparam logic [CNTW-1:0] DIV_CNT = CNTW'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULTI  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic [7:0]      sel_q, sel_d;
  logic            ill_q, ill_d;
  logic            start_q, start_d;

  logic [2:0]      op_lo;
  logic            op_legal;
  logic            op_md;
  logic [7:0]      op_sel;
  logic            accept;

  // Upper opcode bits must be zero for a legal op; illegal ops carry no select.
  assign op_lo    = opcode[2:0];
  assign op_legal = ((opcode >> 3) == '0);
  assign op_md    = op_legal && (op_lo[2:1] == 2'b11);
  assign op_sel   = op_legal ? (8'b1 << op_lo) : 8'b0;

  assign in_ready = (state == IDLE) || (state == RESULT);
  assign accept   = in_valid && in_ready && !kill;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sel_q   <= sel_d;
      ill_q   <= ill_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel_q;
    ill_d   = ill_q;
    start_d = 1'b0;
    if (kill) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
      ill_d   = 1'b0;
    end else begin
      case (state)
        MULTI: begin
          if (cnt == '0) begin
            state_d = RESULT;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        default: begin
          // IDLE and RESULT both accept; RESULT without a new op drains to IDLE.
          if (accept) begin
            sel_d = op_sel;
            ill_d = !op_legal;
            if (op_md) begin
              state_d = MULTI;
              cnt_d   = op_lo[0] ? DIV_CNT : MUL_CNT;
              start_d = 1'b1;
            end else begin
              state_d = RESULT;
              cnt_d   = '0;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            sel_d   = '0;
            ill_d   = 1'b0;
          end
        end
      endcase
    end
  end

  // Pulse-type outputs are masked the same cycle kill is seen.
  assign sel       = sel_q;
  assign busy      = (state == MULTI);
  assign out_valid = (state == RESULT) && !kill;
  assign illegal   = out_valid && ill_q;
  assign md_start  = start_q && !kill;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
// Two instances (long and unit latency) run against a transaction-level reference model.
module tb_alu_op_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       iv  [2];
  logic [4:0] opc [2];
  logic       kl  [2];
  logic       rdy [2];
  logic [7:0] sl  [2];
  logic       mds [2];
  logic       bsy [2];
  logic       ov  [2];
  logic       ill [2];

  alu_op_sequencer #(.OPW(5), .MUL_LAT(4), .DIV_LAT(5)) dut_a (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .opcode(opc[0]), .kill(kl[0]),
    .in_ready(rdy[0]), .sel(sl[0]), .md_start(mds[0]), .busy(bsy[0]),
    .out_valid(ov[0]), .illegal(ill[0])
  );

  alu_op_sequencer #(.OPW(5), .MUL_LAT(1), .DIV_LAT(1)) dut_b (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .opcode(opc[1]), .kill(kl[1]),
    .in_ready(rdy[1]), .sel(sl[1]), .md_start(mds[1]), .busy(bsy[1]),
    .out_valid(ov[1]), .illegal(ill[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: the single outstanding op and the cycle it was accepted in.
  bit         pv   [2];
  logic [4:0] pop  [2];
  int         pacc [2];
  bit         acc_last [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int d, input logic [4:0] op);
    if (op[4:3] != 2'b00 || op[2:1] != 2'b11) return 0;
    if (d == 0) return op[0] ? 5 : 4;
    return 1;
  endfunction

  task automatic step();
    bit e_busy [2];
    bit e_st   [2];
    bit e_ov   [2];
    bit e_ill  [2];
    bit e_rdy  [2];
    logic [7:0] e_sel [2];
    for (int d = 0; d < 2; d++) begin
      int  lat;
      bit  legal;
      bit  md;
      lat   = lat_of(d, pop[d]);
      legal = (pop[d][4:3] == 2'b00);
      md    = (lat > 0);
      e_busy[d] = pv[d] && md && cyc >= pacc[d] + 1 && cyc <= pacc[d] + lat;
      e_st[d]   = pv[d] && md && cyc == pacc[d] + 1 && !kl[d];
      e_ov[d]   = pv[d] && cyc == pacc[d] + 1 + lat && !kl[d];
      e_ill[d]  = e_ov[d] && !legal;
      e_rdy[d]  = !e_busy[d];
      e_sel[d]  = (pv[d] && cyc >= pacc[d] + 1 && cyc <= pacc[d] + 1 + lat && legal)
                  ? (8'd1 << pop[d][2:0]) : 8'd0;
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("in_ready%0d", d),  32'(rdy[d]), 32'(e_rdy[d]));
      check($sformatf("sel%0d", d),       32'(sl[d]),  32'(e_sel[d]));
      check($sformatf("md_start%0d", d),  32'(mds[d]), 32'(e_st[d]));
      check($sformatf("busy%0d", d),      32'(bsy[d]), 32'(e_busy[d]));
      check($sformatf("out_valid%0d", d), 32'(ov[d]),  32'(e_ov[d]));
      check($sformatf("illegal%0d", d),   32'(ill[d]), 32'(e_ill[d]));
      acc_last[d] = iv[d] && e_rdy[d] && !kl[d];
      if (kl[d]) pv[d] = 1'b0;
      if (acc_last[d]) begin
        pv[d]   = 1'b1;
        pop[d]  = opc[d];
        pacc[d] = cyc;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive_both(input logic v, input logic [4:0] op, input logic k);
    for (int d = 0; d < 2; d++) begin
      iv[d] = v; opc[d] = op; kl[d] = k;
    end
  endtask

  task automatic drive_random();
    for (int d = 0; d < 2; d++) begin
      // Producer holds an unaccepted opcode until it is taken or flushed.
      if (!(iv[d] && !acc_last[d] && !kl[d])) begin
        iv[d] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 9) == 0) opc[d] = 5'($urandom);
        else                           opc[d] = 5'($urandom_range(0, 7));
      end
      kl[d] = ($urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0; pop[d] = '0; pacc[d] = 0; acc_last[d] = 1'b0;
    end
    drive_both(1'b0, 5'd0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    step();
    for (int i = 0; i < 6; i++) begin
      drive_both(1'b1, 5'(i), 1'b0);
      step();
    end
    drive_both(1'b0, 5'd0, 1'b0);
    step();
    drive_both(1'b1, 5'b01000, 1'b0);
    step();
    drive_both(1'b0, 5'd0, 1'b0);
    repeat (2) step();
    drive_both(1'b1, 5'd6, 1'b0);
    step();
    drive_both(1'b0, 5'd0, 1'b0);
    repeat (6) step();
    drive_both(1'b1, 5'd7, 1'b0);
    step();
    drive_both(1'b0, 5'd0, 1'b0);
    repeat (2) step();
    drive_both(1'b0, 5'd0, 1'b1);
    step();
    drive_both(1'b1, 5'd0, 1'b0);
    step();
    drive_both(1'b0, 5'd0, 1'b0);
    step();
    drive_both(1'b1, 5'd1, 1'b1);
    step();
    drive_both(1'b0, 5'd0, 1'b0);
    repeat (2) step();

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end
    drive_both(1'b0, 5'd0, 1'b0);
    repeat (8) step();

    // Asynchronous reset in the middle of a multiply.
    drive_both(1'b1, 5'd6, 1'b0);
    step();
    drive_both(1'b0, 5'd0, 1'b0);
    step();
    check("busy_before_reset", 32'(bsy[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("async_busy%0d", d), 32'(bsy[d]), 32'd0);
      check($sformatf("async_sel%0d", d),  32'(sl[d]),  32'd0);
      check($sformatf("async_ov%0d", d),   32'(ov[d]),  32'd0);
      pv[d] = 1'b0;
      acc_last[d] = 1'b0;
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
